// File: rtl/mult8_seq_if.sv
// Requester/consumer handshake bundle for the sequential 8x8 multiplier controller.
interface mult8_seq_if #(
  parameter int OP_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   data_a;
  logic [OP_W-1:0]   data_b;
  logic              out_valid;
  logic              out_ready;
  logic [2*OP_W-1:0] product;
  logic              busy;

  modport master (
    output in_valid, data_a, data_b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, data_a, data_b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mult8_seq_ctrl.sv
// Shift-and-add multiplier controller driving an external 16-bit combinational adder.
// Optional macro MULT8_EARLY_TERM_EN: leave CALC once no multiplier bits remain.
module mult8_seq_ctrl #(
  parameter int OP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mult8_seq_if.slave        bus,
  output logic [2*OP_W-1:0] add_a,
  output logic [2*OP_W-1:0] add_b,
  input  logic [2*OP_W-1:0] add_sum
);

  localparam int PW = 2 * OP_W;
  localparam int CW = $clog2(OP_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand_sh;
  logic [OP_W-1:0] mplier;
  logic [CW-1:0]   count;
  logic [PW-1:0]   product_r;
  logic            calc_last;

`ifdef MULT8_EARLY_TERM_EN
  assign calc_last = (count == CW'(OP_W - 1)) || ((mplier >> 1) == '0);
`else
  assign calc_last = (count == CW'(OP_W - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = CALC;
      CALC: begin
        add_a = acc;
        add_b = mplier[0] ? mcand_sh : '0;
        if (calc_last) state_nxt = DONE;
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: the sum returned for this cycle's operands is folded into acc at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand_sh  <= '0;
      mplier    <= '0;
      count     <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mcand_sh <= {{OP_W{1'b0}}, bus.data_a};
          mplier   <= bus.data_b;
          acc      <= '0;
          count    <= '0;
        end
        CALC: begin
          acc      <= add_sum;
          mcand_sh <= mcand_sh << 1;
          mplier   <= mplier >> 1;
          count    <= count + CW'(1);
          if (calc_last) product_r <= add_sum;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.product   = product_r;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Randomized self-checking bench for mult8_seq_ctrl; models the external adder and the product/latency.
module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] add_a, add_b, add_sum;
  int          n_chk = 0;
  int          n_fail = 0;

  mult8_seq_if #(.OP_W(8)) bus ();

  mult8_seq_ctrl #(.OP_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum)
  );

  assign add_sum = add_a + add_b;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // CALC length from the operand rule, independent of the controller's counters.
  function automatic int calc_len(input logic [7:0] b);
`ifdef MULT8_EARLY_TERM_EN
    int n = 1;
    for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 8;
`endif
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall, input bit pulse);
    int          edges;
    logic [15:0] exp;
    exp = 16'(a) * 16'(b);
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    chk("adder_idle", {add_a, add_b}, 0);
    bus.data_a    = a;
    bus.data_b    = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 40) begin
      chk("in_ready_busy", bus.in_ready, 0);
      chk("busy_calc", bus.busy, 1);
      if (pulse && edges == 2) begin
        bus.in_valid = 1'b1;
        bus.data_a   = 8'h55;
        bus.data_b   = 8'h55;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    bus.in_valid = 1'b0;
    chk("out_valid_seen", bus.out_valid, 1);
    chk("latency", edges, calc_len(b) + 1);
    chk("product", bus.product, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_product", bus.product, exp);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_drop", bus.out_valid, 0);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_busy", bus.busy, 0);
    chk("retain_product", bus.product, exp);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_a    = '0;
    bus.data_b    = '0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_product", bus.product, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h0F, 8'h0F, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 0, 1'b0);
    run_op(8'h00, 8'hAB, 0, 1'b0);
    run_op(8'hAB, 8'h00, 0, 1'b0);
    run_op(8'h12, 8'h34, 5, 1'b0);
    run_op(8'h02, 8'h03, 0, 1'b1);
    run_op(8'hFF, 8'h03, 0, 1'b0);
    run_op(8'h01, 8'h80, 1, 1'b0);

    // Abort mid-calculation with an asynchronous reset.
    @(negedge clk);
    bus.data_a   = 8'hFF;
    bus.data_b   = 8'hF0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_product", bus.product, 0);
    chk("abort_adder", {add_a, add_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h10, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
